// File: rtl/clock_adjust_ctrl.sv
// Clock-adjust control stage: generates the run-mode timebase pulse and turns
// debounced up/down/select buttons into single-cycle adjust pulses with
// direction, including hold-to-repeat and a both-buttons lockout.
module clock_adjust_ctrl #(
    parameter int unsigned TICK_DIV     = 100_000_000,
    parameter int unsigned DEB_CYCLES   = 1_000_000,
    parameter int unsigned REPEAT_DELAY = 50_000_000,
    parameter int unsigned REPEAT_RATE  = 10_000_000,
    parameter int unsigned CNT_W        = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_sel,
    output logic       run_en,
    output logic       adj_en,
    output logic       dir,
    output logic [1:0] field
);

    localparam int unsigned NBTN = 3;
    localparam int unsigned B_UP  = 0;
    localparam int unsigned B_DN  = 1;
    localparam int unsigned B_SEL = 2;

    localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        FLD_RUN     = 2'd0,
        FLD_HOURS   = 2'd1,
        FLD_MINUTES = 2'd2,
        FLD_SECONDS = 2'd3
    } field_e;

    typedef enum logic [1:0] {
        ADJ_IDLE   = 2'd0,
        ADJ_HOLD   = 2'd1,
        ADJ_REPEAT = 2'd2,
        ADJ_LOCK   = 2'd3
    } adj_state_e;

    logic [NBTN-1:0]  raw;
    logic [NBTN-1:0]  sync1_q, sync1_d;
    logic [NBTN-1:0]  sync2_q, sync2_d;
    logic [NBTN-1:0]  deb_q, deb_d;
    logic [NBTN-1:0]  deb_prev_q, deb_prev_d;
    logic [CNT_W-1:0] deb_cnt_q [NBTN];
    logic [CNT_W-1:0] deb_cnt_d [NBTN];
    logic [NBTN-1:0]  rise;

    field_e           field_q, field_d;
    adj_state_e       state_q, state_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             run_en_q, run_en_d;
    logic             adj_en_q, adj_en_d;
    logic             dir_q, dir_d;

    logic up_lvl, dn_lvl, up_rise, dn_rise, sel_rise, held;

    assign raw      = {btn_sel, btn_down, btn_up};
    assign rise     = deb_q & ~deb_prev_q;
    assign up_lvl   = deb_q[B_UP];
    assign dn_lvl   = deb_q[B_DN];
    assign up_rise  = rise[B_UP];
    assign dn_rise  = rise[B_DN];
    assign sel_rise = rise[B_SEL];
    // The button that started the current press is the one recorded in dir.
    assign held     = dir_q ? dn_lvl : up_lvl;

    // Two-flop synchronisers and debounce: a level is accepted after DEB_CYCLES
    // consecutive cycles of disagreement; any agreement restarts the count.
    always_comb begin
        sync1_d    = raw;
        sync2_d    = sync1_q;
        deb_prev_d = deb_q;
        deb_d      = deb_q;
        for (int i = 0; i < int'(NBTN); i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Field select, run-mode timebase and adjust FSM next-state/output logic.
    always_comb begin
        field_d    = field_q;
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        rpt_cnt_d  = rpt_cnt_q;
        run_en_d   = 1'b0;
        adj_en_d   = 1'b0;
        dir_d      = dir_q;

        if (sel_rise) begin
            unique case (field_q)
                FLD_RUN:     field_d = FLD_HOURS;
                FLD_HOURS:   field_d = FLD_MINUTES;
                FLD_MINUTES: field_d = FLD_SECONDS;
                default:     field_d = FLD_RUN;
            endcase
        end

        if (field_q == FLD_RUN) begin
            if (tick_cnt_q == TICK_LAST) begin
                tick_cnt_d = '0;
                run_en_d   = 1'b1;
                dir_d      = 1'b0;
            end else begin
                tick_cnt_d = tick_cnt_q + CNT_W'(1);
            end
        end else begin
            tick_cnt_d = '0;
        end

        if (field_q == FLD_RUN || sel_rise) begin
            state_d   = ADJ_IDLE;
            rpt_cnt_d = '0;
        end else if (up_lvl && dn_lvl) begin
            state_d = ADJ_LOCK;
        end else begin
            unique case (state_q)
                ADJ_IDLE: begin
                    if (up_rise || dn_rise) begin
                        adj_en_d  = 1'b1;
                        dir_d     = dn_rise;
                        state_d   = ADJ_HOLD;
                        rpt_cnt_d = '0;
                    end
                end
                ADJ_HOLD: begin
                    if (!held) begin
                        state_d = ADJ_IDLE;
                    end else if (rpt_cnt_q == DELAY_LAST) begin
                        adj_en_d  = 1'b1;
                        state_d   = ADJ_REPEAT;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
                    end
                end
                ADJ_REPEAT: begin
                    if (!held) begin
                        state_d = ADJ_IDLE;
                    end else if (rpt_cnt_q == RATE_LAST) begin
                        adj_en_d  = 1'b1;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    if (!up_lvl && !dn_lvl) begin
                        state_d = ADJ_IDLE;
                    end
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < int'(NBTN); i++) begin
                deb_cnt_q[i] <= '0;
            end
            field_q    <= FLD_RUN;
            state_q    <= ADJ_IDLE;
            tick_cnt_q <= '0;
            rpt_cnt_q  <= '0;
            run_en_q   <= 1'b0;
            adj_en_q   <= 1'b0;
            dir_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            for (int i = 0; i < int'(NBTN); i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
            field_q    <= field_d;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            rpt_cnt_q  <= rpt_cnt_d;
            run_en_q   <= run_en_d;
            adj_en_q   <= adj_en_d;
            dir_q      <= dir_d;
        end
    end

    assign run_en = run_en_q;
    assign adj_en = adj_en_q;
    assign dir    = dir_q;
    assign field  = field_q;

endmodule

// File: tb/tb_clock_adjust_ctrl.sv
// Directed bench for clock_adjust_ctrl: expected pulses (cycle, kind, dir) are
// queued as stimulus is applied and matched by a monitor as the DUT emits them.
module tb_clock_adjust_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_up, btn_down, btn_sel;
    logic       run_en, adj_en, dir;
    logic [1:0] field;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int   cyc;
        logic is_adj;
        logic dir;
    } ev_t;

    ev_t exp_q[$];

    clock_adjust_ctrl #(
        .TICK_DIV    (10),
        .DEB_CYCLES  (4),
        .REPEAT_DELAY(20),
        .REPEAT_RATE (5),
        .CNT_W       (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .btn_sel (btn_sel),
        .run_en  (run_en),
        .adj_en  (adj_en),
        .dir     (dir),
        .field   (field)
    );

    always #5 clk = ~clk;

    // Rising-edge count; at each falling edge cyc equals the number of edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic push(input int c, input logic a, input logic d);
        ev_t e;
        e.cyc    = c;
        e.is_adj = a;
        e.dir    = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Press select for 8 cycles; field must hold at +6 and advance at +7.
    task automatic press_sel(input logic [1:0] nf);
        logic [1:0] of;
        of = nf - 2'd1;
        btn_sel = 1'b1;
        repeat (6) @(negedge clk);
        check("field_before_sel", 32'(field), 32'(of));
        @(negedge clk);
        check("field_after_sel", 32'(field), 32'(nf));
        @(negedge clk);
        btn_sel = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    // Match every emitted pulse against the head of the expectation queue.
    always @(negedge clk) begin : mon
        ev_t e;
        if (run_en || adj_en) begin
            check("pulse_overlap", 32'(run_en & adj_en), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'({run_en, adj_en}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_cycle", 32'(cyc), 32'(e.cyc));
                check("pulse_kind_adj", 32'(adj_en), 32'(e.is_adj));
                check("pulse_dir", 32'(dir), 32'(e.dir));
            end
        end
    end

    initial begin
        int r, c, d, u, v, w, x, y;
        reset    = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_sel  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_run_en", 32'(run_en), 32'd0);
        check("reset_adj_en", 32'(adj_en), 32'd0);
        check("reset_dir", 32'(dir), 32'd0);
        check("reset_field", 32'(field), 32'd0);

        // Run mode timebase.
        reset = 1'b1;
        r = cyc;
        for (int k = 1; k <= 5; k++) push(r + 10 * k, 1'b0, 1'b0);
        wait_until(r + 45);
        check("run_field", 32'(field), 32'd0);

        // Field cycling; timebase restarts on return to RUN.
        press_sel(2'd1);
        press_sel(2'd2);
        press_sel(2'd3);
        c = cyc;
        push(c + 17, 1'b0, 1'b0);
        push(c + 27, 1'b0, 1'b0);
        press_sel(2'd0);
        press_sel(2'd1);
        check("queue_after_fields", 32'(exp_q.size()), 32'd0);
        press_sel(2'd2);

        // Hold down in MINUTES: first pulse, delay, then repeat until release.
        d = cyc;
        push(d + 7, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) push(d + 27 + 5 * k, 1'b1, 1'b1);
        btn_down = 1'b1;
        wait_until(d + 60);
        btn_down = 1'b0;
        wait_until(d + 80);
        check("queue_after_repeat", 32'(exp_q.size()), 32'd0);

        // Bouncing up button, then a clean press.
        for (int i = 0; i < 16; i++) begin
            btn_up = ~btn_up;
            repeat (2) @(negedge clk);
        end
        u = cyc;
        btn_up = 1'b1;
        push(u + 7, 1'b1, 1'b0);
        wait_until(u + 10);
        btn_up = 1'b0;
        wait_until(u + 25);
        check("queue_after_bounce", 32'(exp_q.size()), 32'd0);

        // Both buttons lock out; only a fresh press after full release fires.
        v = cyc;
        btn_up = 1'b1;
        push(v + 7, 1'b1, 1'b0);
        wait_until(v + 10);
        btn_down = 1'b1;
        wait_until(v + 40);
        btn_down = 1'b0;
        wait_until(v + 60);
        btn_up = 1'b0;
        wait_until(v + 75);
        check("queue_during_lock", 32'(exp_q.size()), 32'd0);
        w = cyc;
        btn_up = 1'b1;
        push(w + 7, 1'b1, 1'b0);
        wait_until(w + 10);
        btn_up = 1'b0;
        wait_until(w + 25);
        check("queue_after_unlock", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset while a repeat pulse is on the outputs.
        x = cyc;
        btn_down = 1'b1;
        push(x + 7, 1'b1, 1'b1);
        push(x + 27, 1'b1, 1'b1);
        push(x + 32, 1'b1, 1'b1);
        wait_until(x + 32);
        #2 reset = 1'b0;
        #1;
        check("async_run_en", 32'(run_en), 32'd0);
        check("async_adj_en", 32'(adj_en), 32'd0);
        check("async_dir", 32'(dir), 32'd0);
        check("async_field", 32'(field), 32'd0);
        btn_down = 1'b0;
        repeat (2) @(negedge clk);
        check("queue_before_rerun", 32'(exp_q.size()), 32'd0);
        reset = 1'b1;
        y = cyc;
        push(y + 10, 1'b0, 1'b0);
        push(y + 20, 1'b0, 1'b0);
        wait_until(y + 25);
        check("queue_after_reset", 32'(exp_q.size()), 32'd0);
        check("field_after_reset", 32'(field), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
